// File: rtl/roc_link_pkg.sv
// Shared host-link constants and state encodings.
// Used by the output reporter and its byte transmitter.
package roc_link_pkg;

    localparam int unsigned ROC_CLK_HZ       = 50_000_000;
    localparam int unsigned ROC_BAUD         = 115_200;
    localparam int unsigned ROC_CLKS_PER_BIT = ROC_CLK_HZ / ROC_BAUD;

    localparam logic [7:0] ROC_FRAME_HDR = 8'hA5;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_HDR,
        FR_DATA,
        FR_CSUM,
        FR_DRAIN
    } frame_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_BITS,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter with a valid/ready byte input.
// Ready rises in the last stop-bit cycle so bytes chain without a gap.
module uart_tx_byte
    import roc_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ROC_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign o_ready = (state_q == TX_IDLE) || (state_q == TX_STOP && bit_end);
    assign o_tx    = tx_q;

    // Bit timing and shift sequencing; an accepted byte always restarts at START.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        unique case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_BITS;
                    bit_d   = 3'd0;
                    tx_d    = sh_q[0];
                end
            end
            TX_BITS: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        if (i_valid && o_ready) begin
            state_d = TX_START;
            cnt_d   = '0;
            bit_d   = 3'd0;
            sh_d    = i_data;
            tx_d    = 1'b0;
        end
    end

    // Transmitter state; the line returns high the moment reset asserts.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/roc_output_reporter.sv
// Frames a snapshot of the core output vector as HDR, data, checksum
// and streams it over UART; one request may queue behind a busy frame.
module roc_output_reporter
    import roc_link_pkg::*;
#(
    parameter int unsigned ROC_OUTPUTS      = 8,
    parameter int unsigned ROC_OUTPUT_BYTES = (ROC_OUTPUTS + 7) >> 3,
    parameter int unsigned CLKS_PER_BIT     = ROC_CLKS_PER_BIT,
    parameter logic [7:0]  FRAME_HDR        = ROC_FRAME_HDR
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [ROC_OUTPUTS-1:0] i_roc_outputs,
    input  logic                   i_req,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned SW = ROC_OUTPUT_BYTES * 8;
    localparam int unsigned IW = (ROC_OUTPUT_BYTES > 1) ? $clog2(ROC_OUTPUT_BYTES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(ROC_OUTPUT_BYTES - 1);

    frame_state_e  state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [SW-1:0] snap_q, snap_d;
    logic          pend_q, pend_d;

    logic [SW-1:0] snap_in;
    logic [7:0]    data_byte;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          launch;

    assign o_busy    = (state_q != FR_IDLE);
    assign data_byte = snap_q[{idx_q, 3'b000} +: 8];

    // Zero-pad the live vector up to a whole number of bytes.
    always_comb begin
        snap_in = '0;
        snap_in[ROC_OUTPUTS-1:0] = i_roc_outputs;
    end

    // Frame sequencing; a launch hands the header straight to the
    // transmitter so the start bit appears in the next cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        snap_d   = snap_q;
        pend_d   = pend_q;
        tx_valid = 1'b0;
        tx_data  = FRAME_HDR;
        o_done   = 1'b0;
        launch   = 1'b0;
        unique case (state_q)
            FR_IDLE: begin
                launch = i_req || pend_q;
            end
            FR_HDR: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d = FR_DATA;
                end
            end
            FR_DATA: begin
                tx_valid = 1'b1;
                tx_data  = data_byte;
                if (tx_ready) begin
                    csum_d = csum_q + data_byte;
                    if (idx_q == IDX_LAST) begin
                        state_d = FR_CSUM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FR_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) begin
                    state_d = FR_DRAIN;
                end
            end
            FR_DRAIN: begin
                if (tx_ready) begin
                    o_done = 1'b1;
                    launch = i_req || pend_q;
                    if (!launch) begin
                        state_d = FR_IDLE;
                    end
                end
            end
            default: state_d = FR_IDLE;
        endcase
        if (launch) begin
            tx_valid = 1'b1;
            tx_data  = FRAME_HDR;
            snap_d   = snap_in;
            idx_d    = '0;
            csum_d   = 8'h00;
            pend_d   = 1'b0;
            state_d  = tx_ready ? FR_DATA : FR_HDR;
        end else if (o_busy && i_req) begin
            pend_d = 1'b1;
        end
    end

    // Frame registers; reset abandons any frame in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= FR_IDLE;
            idx_q   <= '0;
            csum_q  <= 8'h00;
            snap_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            snap_q  <= snap_d;
            pend_q  <= pend_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (tx_valid),
        .i_data  (tx_data),
        .o_ready (tx_ready),
        .o_tx    (o_tx)
    );

endmodule
